// File: rtl/regfile_cmd_pkg.sv
// Shared constants and FSM encoding for the RegFile byte-stream command front end.
package regfile_cmd_pkg;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_GET_ADDR = 3'd1;
    localparam logic [STATE_W-1:0] ST_GET_DATA = 3'd2;
    localparam logic [STATE_W-1:0] ST_WRITE    = 3'd3;
    localparam logic [STATE_W-1:0] ST_READ     = 3'd4;
    localparam logic [STATE_W-1:0] ST_WAIT_RD  = 3'd5;
    localparam logic [STATE_W-1:0] ST_SEND     = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = ST_IDLE,
        GET_ADDR = ST_GET_ADDR,
        GET_DATA = ST_GET_DATA,
        WRITE    = ST_WRITE,
        READ     = ST_READ,
        WAIT_RD  = ST_WAIT_RD,
        SEND     = ST_SEND
    } state_t;

endpackage

// File: rtl/rx_timeout_cnt.sv
// Counts idle cycles while enabled; flags the cycle on which the TIMEOUT-th idle cycle ends.
module rx_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expired = enable && !clear && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear || !enable || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_cmd_ctrl.sv
// Parses AA/BB command frames from a byte stream into RegFile writes/reads and
// returns read data LSB-first. Handshakes: a byte moves on a cycle where valid & ready are both high.
module regfile_cmd_ctrl
    import regfile_cmd_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ADDR    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       RxData,
    input  logic             RxValid,
    output logic             RxReady,
    output logic [7:0]       TxData,
    output logic             TxValid,
    input  logic             TxReady,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    output logic             WrEn,
    output logic             RdEn,
    input  logic [WIDTH-1:0] RdData,
    output logic             Busy,
    output logic             ErrPulse,
    output state_t           dbg_state
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t           state;
    logic             is_write;
    logic             addr_bad;
    logic [IDX_W-1:0] byte_idx;
    logic [WIDTH-1:0] data_sr;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] shift_in;
    logic             rx_fire;
    logic             tx_fire;
    logic             timer_en;
    logic             expired;

    assign rx_fire   = RxValid & RxReady;
    assign tx_fire   = TxValid & TxReady;
    assign timer_en  = (state == GET_ADDR) || (state == GET_DATA);
    assign shift_in  = WIDTH'({RxData, data_sr} >> 8);
    assign dbg_state = state;

    rx_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (CLK),
        .rst_n  (RST),
        .clear  (rx_fire),
        .enable (timer_en),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            is_write <= 1'b0;
            addr_bad <= 1'b0;
            byte_idx <= '0;
            data_sr  <= '0;
            tx_sr    <= '0;
            RxReady  <= 1'b0;
            TxData   <= '0;
            TxValid  <= 1'b0;
            Address  <= '0;
            WrData   <= '0;
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            Busy     <= 1'b0;
            ErrPulse <= 1'b0;
        end else begin
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            ErrPulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    RxReady <= 1'b1;
                    Busy    <= 1'b0;
                    if (rx_fire) begin
                        if (RxData == CMD_WR || RxData == CMD_RD) begin
                            is_write <= (RxData == CMD_WR);
                            state    <= GET_ADDR;
                            Busy     <= 1'b1;
                        end else begin
                            ErrPulse <= 1'b1;
                        end
                    end
                end
                GET_ADDR: begin
                    if (expired) begin
                        ErrPulse <= 1'b1;
                        state    <= IDLE;
                        Busy     <= 1'b0;
                    end else if (rx_fire) begin
                        addr_bad <= (int'(RxData) >= DEPTH);
                        byte_idx <= '0;
                        // Out-of-range addresses never reach Address, so it keeps its last good value.
                        if (int'(RxData) < DEPTH) begin
                            Address <= ADDR'(RxData);
                        end
                        if (is_write) begin
                            state <= GET_DATA;
                        end else if (int'(RxData) >= DEPTH) begin
                            ErrPulse <= 1'b1;
                            state    <= IDLE;
                            Busy     <= 1'b0;
                        end else begin
                            RdEn    <= 1'b1;
                            RxReady <= 1'b0;
                            state   <= READ;
                        end
                    end
                end
                GET_DATA: begin
                    if (expired) begin
                        ErrPulse <= 1'b1;
                        state    <= IDLE;
                        Busy     <= 1'b0;
                    end else if (rx_fire) begin
                        data_sr <= shift_in;
                        if (byte_idx == LAST_IDX) begin
                            if (addr_bad) begin
                                ErrPulse <= 1'b1;
                                state    <= IDLE;
                                Busy     <= 1'b0;
                            end else begin
                                WrData  <= shift_in;
                                WrEn    <= 1'b1;
                                RxReady <= 1'b0;
                                state   <= WRITE;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    RxReady <= 1'b1;
                    Busy    <= 1'b0;
                    state   <= IDLE;
                end
                READ: begin
                    state <= WAIT_RD;
                end
                WAIT_RD: begin
                    TxData   <= RdData[7:0];
                    tx_sr    <= RdData >> 8;
                    TxValid  <= 1'b1;
                    byte_idx <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_fire) begin
                        if (byte_idx == LAST_IDX) begin
                            TxValid <= 1'b0;
                            RxReady <= 1'b1;
                            Busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            TxData   <= tx_sr[7:0];
                            tx_sr    <= tx_sr >> 8;
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
